video_timing_ctrl: RTL
======================

// Module: video_timing_ctrl
// PURPOSE
// - Raster timing controller for the video pipeline: drives hs/vs/de and pixel coordinates.
// - Pulls pixels from an upstream source with a ready/valid handshake and forwards them.
// - Supports graceful frame-aligned start/stop and flags pixel underflow.
// PARAMETERS
// - H_ACT 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal phase lengths (pixels).
// - V_ACT 480 / V_FP 10 / V_SYNC 2 / V_BP 33 : vertical phase lengths (lines).
// - SYNC_POL 0 : sync active level (0 = active-low).
// - DW 24 : pixel data width.
// PORTS
// - clk        in   1   pixel clock; single clock domain.
// - rst        in   1   synchronous, active-high reset.
// - i_en       in   1   run request; sampled each cycle.
// - pix_valid  in   1   upstream pixel available.
// - pix_data   in   DW  upstream pixel.
// - pix_rdy    out  1   pixel consumed this cycle (== o_de).
// - i_clr_uf   in   1   clear sticky underflow.
// - o_hs/o_vs  out  1   sync outputs, polarity per SYNC_POL.
// - o_de       out  1   active-video enable.
// - o_x / o_y  out  XW/YW  active coordinates ($clog2(H_ACT)/$clog2(V_ACT) bits); 0 when !o_de.
// - o_rgb      out  DW  pix_data when o_de && pix_valid, else 0.
// - o_sof      out  1   one-cycle pulse at h=0,v=0 of every frame.
// - o_eol      out  1   asserted with o_de on last active pixel of each line.
// - o_busy     out  1   high while in RUN or STOP.
// - o_underflow out 1   sticky: o_de && !pix_valid occurred.
// BEHAVIOUR
// - Reset: state IDLE, h=v=0, o_hs=o_vs=~SYNC_POL, all other outputs 0; applies mid-frame too.
// - FSM IDLE -> RUN on edge with i_en=1 (h=0,v=0 in following cycle); RUN -> STOP when i_en=0;
//   STOP -> RUN if i_en returns before frame end; STOP -> IDLE after h=H_TOT-1,v=V_TOT-1.
// - Outputs are combinational decodes of registered state (h,v,FSM); in IDLE same as reset.
// - h: 0..H_TOT-1, H_TOT=H_SYNC+H_BP+H_ACT+H_FP; wraps to 0 and increments v.
// - v: 0..V_TOT-1, wraps to 0 (next frame). Phase order both axes: SYNC, BP, ACT, FP.
// - hs active for h<H_SYNC; vs active for whole lines v<V_SYNC.
// - de when H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACT and same form on v; x=h-(H_SYNC+H_BP).
// - Underflow: set on edge after a cycle with o_de && !pix_valid; cleared by i_clr_uf;
//   set wins over simultaneous clear. Unaffected by IDLE; cleared only by rst/i_clr_uf.
// - pix_valid outside de is ignored (no consumption); pix_rdy never depends on pix_valid.
// - Width rules: counters sized $clog2(H_TOT)/$clog2(V_TOT); compares unsigned, no overflow.
// STRUCTURE
// - video_timing_pkg: state enum (IDLE/RUN/STOP), phase enum, width helper functions.
// - Sub-module video_axis_cnt (wrap counter + phase decode) instantiated for h and v;
//   v instance advanced by h wrap strobe.
// TESTING (small config: H 2/1/4/1 sync/bp/act/fp -> H_TOT=8; V 1/1/3/1 -> V_TOT=6; 48 cyc/frame)
// - rst=1 held 5 cycles -> o_hs=o_vs=1, o_de/o_sof/o_busy/o_underflow=0, o_x=o_y=0.
// - i_en=1, pix_valid=1 -> o_hs low h=0..1 each line, o_vs low line 0, 12 de cycles/frame
//   at h=3..6 on v=2..4, o_eol at x=3, o_sof every 48 cycles, o_underflow stays 0.
// - pix_valid=0 at x=2,y=1 -> o_rgb=0 that cycle, o_underflow=1 next and held until i_clr_uf.
// - i_clr_uf and new underflow same cycle -> o_underflow remains 1.
// - i_en=0 at v=3 -> frame completes to h=7,v=5, then o_busy=0; i_en=1 restarts with o_sof.
// - rst pulse at v=2,h=4 -> next cycle IDLE outputs, restart at h=0,v=0 when i_en=1.

Source files
------------

// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module      : video_timing_pkg
// Description : Shared state/phase encodings and width helpers for the
//               video timing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_STOP = 2'd2;

    // Axis phases, in raster order
    localparam logic [1:0] c_PH_SYNC = 2'd0;
    localparam logic [1:0] c_PH_BP   = 2'd1;
    localparam logic [1:0] c_PH_ACT  = 2'd2;
    localparam logic [1:0] c_PH_FP   = 2'd3;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_axis_cnt.sv
// ============================================================================
// Module      : video_axis_cnt
// Description : Wrapping position counter for one raster axis with
//               SYNC/BP/ACT/FP phase decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int SYNC = 2,
    parameter int BP   = 1,
    parameter int ACT  = 4,
    parameter int FP   = 1,
    parameter int W    = cnt_w(SYNC + BP + ACT + FP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_adv,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap,
    output logic [1:0]   o_phase
);

    localparam int         c_TOT       = SYNC + BP + ACT + FP;
    localparam logic [W-1:0] c_LAST    = W'(c_TOT - 1);
    localparam logic [W-1:0] c_BP_ST   = W'(SYNC);
    localparam logic [W-1:0] c_ACT_ST  = W'(SYNC + BP);
    localparam logic [W-1:0] c_FP_ST   = W'(SYNC + BP + ACT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = i_adv && (r_cnt == c_LAST);

    always_comb begin
        o_phase = c_PH_FP;
        if (r_cnt < c_BP_ST) begin
            o_phase = c_PH_SYNC;
        end else if (r_cnt < c_ACT_ST) begin
            o_phase = c_PH_BP;
        end else if (r_cnt < c_FP_ST) begin
            o_phase = c_PH_ACT;
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_timing_ctrl.sv
// ============================================================================
// Module      : video_timing_ctrl
// Description : Raster timing controller: hs/vs/de, active coordinates,
//               ready/valid pixel forwarding, frame-aligned start/stop and
//               sticky underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int   H_ACT    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACT    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   DW       = 24,
    localparam int  XW       = cnt_w(H_ACT),
    localparam int  YW       = cnt_w(V_ACT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          pix_rdy,
    input  logic          i_clr_uf,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_de,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [DW-1:0] o_rgb,
    output logic          o_sof,
    output logic          o_eol,
    output logic          o_busy,
    output logic          o_underflow
);

    localparam int HW = cnt_w(H_SYNC + H_BP + H_ACT + H_FP);
    localparam int VW = cnt_w(V_SYNC + V_BP + V_ACT + V_FP);

    localparam logic [HW-1:0] c_H_ACT_ST = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] c_H_EOL    = HW'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [VW-1:0] c_V_ACT_ST = VW'(V_SYNC + V_BP);

    logic [1:0]    r_state;
    logic          r_underflow;

    logic          w_busy;
    logic          w_idle;
    logic          w_de;
    logic [HW-1:0] w_h_cnt;
    logic          w_h_wrap;
    logic [1:0]    w_h_phase;
    logic [VW-1:0] w_v_cnt;
    logic          w_v_wrap;
    logic [1:0]    w_v_phase;

    assign w_idle = (r_state == c_ST_IDLE);
    assign w_busy = !w_idle;

    // Counters sit at 0 while idle so the first running cycle is h=0,v=0.
    video_axis_cnt #(
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .ACT  (H_ACT),
        .FP   (H_FP),
        .W    (HW)
    ) u_h_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_idle),
        .i_adv   (w_busy),
        .o_cnt   (w_h_cnt),
        .o_wrap  (w_h_wrap),
        .o_phase (w_h_phase)
    );

    video_axis_cnt #(
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .ACT  (V_ACT),
        .FP   (V_FP),
        .W    (VW)
    ) u_v_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_idle),
        .i_adv   (w_h_wrap),
        .o_cnt   (w_v_cnt),
        .o_wrap  (w_v_wrap),
        .o_phase (w_v_phase)
    );

    // w_v_wrap marks the final pixel of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_en) r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (!i_en) r_state <= c_ST_STOP;
                end
                c_ST_STOP: begin
                    if (i_en) begin
                        r_state <= c_ST_RUN;
                    end else if (w_v_wrap) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_de && !pix_valid) begin
            r_underflow <= 1'b1;
        end else if (i_clr_uf) begin
            r_underflow <= 1'b0;
        end
    end

    assign w_de = w_busy && (w_h_phase == c_PH_ACT) && (w_v_phase == c_PH_ACT);

    assign o_de        = w_de;
    assign pix_rdy     = w_de;
    assign o_hs        = (w_busy && (w_h_phase == c_PH_SYNC)) ? SYNC_POL : ~SYNC_POL;
    assign o_vs        = (w_busy && (w_v_phase == c_PH_SYNC)) ? SYNC_POL : ~SYNC_POL;
    assign o_x         = w_de ? XW'(w_h_cnt - c_H_ACT_ST) : '0;
    assign o_y         = w_de ? YW'(w_v_cnt - c_V_ACT_ST) : '0;
    assign o_rgb       = (w_de && pix_valid) ? pix_data : '0;
    assign o_sof       = w_busy && (w_h_cnt == '0) && (w_v_cnt == '0);
    assign o_eol       = w_de && (w_h_cnt == c_H_EOL);
    assign o_busy      = w_busy;
    assign o_underflow = r_underflow;

endmodule

`default_nettype wire
